// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and Wishbone cycle-type codes for wb_bram_arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone B4 bus bundle shared by masters, arbiter and wb_bram
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst,
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  clk, rst,
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_arb_mux.sv
// rtl/wb_arb_mux.sv - combinational request mux and response demux steered by the one-hot grant
module wb_arb_mux (
  input  logic [1:0]  i_grant,
  input  logic        i_timeout,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic [2:0]  i_m0_cti,
  input  logic [1:0]  i_m0_bte,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic        o_m0_rty,
  output logic [31:0] o_m0_dat,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic [2:0]  i_m1_cti,
  input  logic [1:0]  i_m1_bte,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_m1_rty,
  output logic [31:0] o_m1_dat,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic [2:0]  o_s_cti,
  output logic [1:0]  o_s_bte,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic        i_s_rty,
  input  logic [31:0] i_s_dat
);
  logic w_own0;
  logic w_own1;

  // Responses reach a master only while it owns the slave and still holds cyc.
  assign w_own0 = i_grant[0] & i_m0_cyc;
  assign w_own1 = i_grant[1] & i_m1_cyc;

  always_comb begin
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    o_s_we  = 1'b0;
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_cti = '0;
    o_s_bte = '0;
    if (i_grant[0]) begin
      o_s_cyc = i_m0_cyc;
      o_s_stb = i_m0_stb;
      o_s_we  = i_m0_we;
      o_s_adr = i_m0_adr;
      o_s_dat = i_m0_dat;
      o_s_sel = i_m0_sel;
      o_s_cti = i_m0_cti;
      o_s_bte = i_m0_bte;
    end else if (i_grant[1]) begin
      o_s_cyc = i_m1_cyc;
      o_s_stb = i_m1_stb;
      o_s_we  = i_m1_we;
      o_s_adr = i_m1_adr;
      o_s_dat = i_m1_dat;
      o_s_sel = i_m1_sel;
      o_s_cti = i_m1_cti;
      o_s_bte = i_m1_bte;
    end
    if (i_timeout) begin
      o_s_cyc = 1'b0;
      o_s_stb = 1'b0;
    end
  end

  assign o_m0_ack = w_own0 & i_s_ack;
  assign o_m0_err = w_own0 & (i_s_err | i_timeout);
  assign o_m0_rty = w_own0 & i_s_rty;
  assign o_m0_dat = i_s_dat;
  assign o_m1_ack = w_own1 & i_s_ack;
  assign o_m1_err = w_own1 & (i_s_err | i_timeout);
  assign o_m1_rty = w_own1 & i_s_rty;
  assign o_m1_dat = i_s_dat;

endmodule

// File: rtl/wb_bram_arbiter.sv
// rtl/wb_bram_arbiter.sv - round-robin two-master Wishbone arbiter in front of wb_bram
// Optional stall watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_bram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      wb_m0,
  wshb_if.slave      wb_m1,
  wshb_if.master     wb_s,
  output logic [1:0] grant,
  output logic       busy
);
  arb_state_t r_state;
  logic       r_last_served;
  logic       w_timeout;
  logic       w_m0_ack;
  logic       w_m1_ack;

  assign grant = {r_state == OWN1, r_state == OWN0};
  assign busy  = (r_state != IDLE);
  assign wb_m0.ack = w_m0_ack;
  assign wb_m1.ack = w_m1_ack;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 w_owner_stb;
  logic                 w_owner_cyc;
  logic                 w_leave;

  assign w_owner_stb = (grant[0] & wb_m0.stb) | (grant[1] & wb_m1.stb);
  assign w_owner_cyc = (grant[0] & wb_m0.cyc) | (grant[1] & wb_m1.cyc);
  assign w_leave     = busy & ~w_owner_cyc;
  assign w_timeout   = &r_wdog;

  // Saturating at all-ones fires the timeout; it clears on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_timeout || w_leave || !w_owner_stb || w_m0_ack || w_m1_ack) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  logic w_unused_timeout_w;

  assign w_timeout          = 1'b0;
  assign w_unused_timeout_w = (TIMEOUT_W > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_served <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (wb_m0.cyc && (!wb_m1.cyc || r_last_served)) begin
            r_state <= OWN0;
          end else if (wb_m1.cyc) begin
            r_state <= OWN1;
          end
        end
        OWN0: begin
          if (w_timeout) begin
            r_state       <= IDLE;
            r_last_served <= 1'b0;
          end else if (!wb_m0.cyc) begin
            r_state       <= wb_m1.cyc ? OWN1 : IDLE;
            r_last_served <= 1'b0;
          end
        end
        OWN1: begin
          if (w_timeout) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
          end else if (!wb_m1.cyc) begin
            r_state       <= wb_m0.cyc ? OWN0 : IDLE;
            r_last_served <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  wb_arb_mux u_mux (
    .i_grant   (grant),
    .i_timeout (w_timeout),
    .i_m0_cyc  (wb_m0.cyc),
    .i_m0_stb  (wb_m0.stb),
    .i_m0_we   (wb_m0.we),
    .i_m0_adr  (wb_m0.adr),
    .i_m0_dat  (wb_m0.dat_ms),
    .i_m0_sel  (wb_m0.sel),
    .i_m0_cti  (wb_m0.cti),
    .i_m0_bte  (wb_m0.bte),
    .o_m0_ack  (w_m0_ack),
    .o_m0_err  (wb_m0.err),
    .o_m0_rty  (wb_m0.rty),
    .o_m0_dat  (wb_m0.dat_sm),
    .i_m1_cyc  (wb_m1.cyc),
    .i_m1_stb  (wb_m1.stb),
    .i_m1_we   (wb_m1.we),
    .i_m1_adr  (wb_m1.adr),
    .i_m1_dat  (wb_m1.dat_ms),
    .i_m1_sel  (wb_m1.sel),
    .i_m1_cti  (wb_m1.cti),
    .i_m1_bte  (wb_m1.bte),
    .o_m1_ack  (w_m1_ack),
    .o_m1_err  (wb_m1.err),
    .o_m1_rty  (wb_m1.rty),
    .o_m1_dat  (wb_m1.dat_sm),
    .o_s_cyc   (wb_s.cyc),
    .o_s_stb   (wb_s.stb),
    .o_s_we    (wb_s.we),
    .o_s_adr   (wb_s.adr),
    .o_s_dat   (wb_s.dat_ms),
    .o_s_sel   (wb_s.sel),
    .o_s_cti   (wb_s.cti),
    .o_s_bte   (wb_s.bte),
    .i_s_ack   (wb_s.ack),
    .i_s_err   (wb_s.err),
    .i_s_rty   (wb_s.rty),
    .i_s_dat   (wb_s.dat_sm)
  );

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb/tb_wb_bram_arbiter.sv - directed and randomized checks of wb_bram_arbiter against a BRAM stub
`timescale 1ns/1ps
module tb_wb_bram_arbiter;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst;
  logic [1:0] grant;
  logic       busy;

  always #5 clk = ~clk;
  assign rst = ~rst_n;

  wshb_if wb_m0_if (.clk(clk), .rst(rst));
  wshb_if wb_m1_if (.clk(clk), .rst(rst));
  wshb_if wb_s_if  (.clk(clk), .rst(rst));

  wb_bram_arbiter #(.TIMEOUT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_m0 (wb_m0_if),
    .wb_m1 (wb_m1_if),
    .wb_s  (wb_s_if),
    .grant (grant),
    .busy  (busy)
  );

  // BRAM stub: one ack per two cycles, registered read data
  logic [31:0] mem [0:255];
  logic        r_sack = 1'b0;
  logic [31:0] r_sdat = 32'h0;
  logic        stub_noack = 1'b0;

  always @(posedge clk) begin
    if (wb_s_if.cyc && wb_s_if.stb && !r_sack && !stub_noack) begin
      r_sack <= 1'b1;
      r_sdat <= mem[wb_s_if.adr[9:2]];
      if (wb_s_if.we) mem[wb_s_if.adr[9:2]] <= wb_s_if.dat_ms;
    end else begin
      r_sack <= 1'b0;
    end
  end

  assign wb_s_if.ack    = r_sack;
  assign wb_s_if.err    = 1'b0;
  assign wb_s_if.rty    = 1'b0;
  assign wb_s_if.dat_sm = r_sdat;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      wb_m0_if.cyc = cyc; wb_m0_if.stb = cyc; wb_m0_if.we = we; wb_m0_if.adr = adr;
      wb_m0_if.dat_ms = dat; wb_m0_if.sel = 4'hF; wb_m0_if.cti = cti; wb_m0_if.bte = 2'b00;
    end else begin
      wb_m1_if.cyc = cyc; wb_m1_if.stb = cyc; wb_m1_if.we = we; wb_m1_if.adr = adr;
      wb_m1_if.dat_ms = dat; wb_m1_if.sel = 4'hF; wb_m1_if.cti = cti; wb_m1_if.bte = 2'b00;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? wb_m0_if.ack : wb_m1_if.ack;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? wb_m0_if.dat_sm : wb_m1_if.dat_sm;
  endfunction

  function automatic logic [1:0] grant_for(input int own);
    if (own == 0) return 2'b01;
    if (own == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where master m sees ack; the other master must stay silent.
  task automatic wait_ack(input int m, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ack_of(m) && n < 50) begin
      check({tag, "_other_ack"}, ack_of(1 - m), 1'b0);
      @(negedge clk);
      n++;
    end
    check({tag, "_ack"}, ack_of(m), 1'b1);
    check({tag, "_other_ack_on_ack"}, ack_of(1 - m), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  logic cyc_m [2];
  int   own;
  int   last;
  int   pref;
  int   beats;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", grant, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_s_cyc", wb_s_if.cyc, 1'b0);
    rst_n = 1'b1;
    tick;

    // tie from reset, handover, round-robin tie
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, CTI_CLASSIC);
    tick;
    check("tie1_grant", grant, 2'b01);
    check("tie1_busy", busy, 1'b1);
    tick;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    #1;
    check("handover_s_cyc", wb_s_if.cyc, 1'b0);
    check("handover_old_grant", grant, 2'b01);
    tick;
    check("handover_grant", grant, 2'b10);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    check("idle_after_m1", grant, 2'b00);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, CTI_CLASSIC);
    tick;
    check("tie2_grant", grant, 2'b01);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    check("tie2_idle", grant, 2'b00);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, CTI_CLASSIC);
    tick;
    check("tie3_rr_grant", grant, 2'b10);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    tick;

    // single write and read-back by m1
    drive(1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, CTI_CLASSIC);
    wait_ack(1, "wr1");
    tick;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
    wait_ack(1, "rd1");
    check("rd1_data", dat_of(1), 32'hDEADBEEF);
    tick;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;

    // contention: m1 writes while m0 waits, then m0 reads
    drive(1, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, CTI_CLASSIC);
    tick;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0, CTI_CLASSIC);
    wait_ack(1, "cw");
    tick;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    wait_ack(0, "cr");
    check("cr_data", dat_of(0), 32'hA5A5A5A5);
    tick;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;

    // 8-beat incrementing burst on m0 with m1 pending
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_INCR);
    tick;
    check("burst_grant", grant, 2'b01);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h0, CTI_CLASSIC);
    beats = 0;
    for (int b = 0; b < 8; b++) begin
      wait_ack(0, "burst");
      if (ack_of(0)) beats++;
      check("burst_hold_grant", grant, 2'b01);
      tick;
      if (b < 7) drive(0, 1'b1, 1'b0, 32'h100 + 32'(4 * (b + 1)), 32'h0, (b == 6) ? CTI_END : CTI_INCR);
      else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    end
    check("burst_beats", beats, 8);
    #1;
    check("burst_drop_s_cyc", wb_s_if.cyc, 1'b0);
    check("burst_drop_grant", grant, 2'b01);
    tick;
    check("burst_m1_granted", grant, 2'b10);
    wait_ack(1, "burst_m1");
    tick;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;

    // reset in the middle of a burst
    drive(0, 1'b1, 1'b0, 32'h300, 32'h0, CTI_INCR);
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("rst_mid_grant", grant, 2'b00);
    check("rst_mid_s_cyc", wb_s_if.cyc, 1'b0);
    check("rst_mid_s_stb", wb_s_if.stb, 1'b0);
    check("rst_mid_m0_ack", ack_of(0), 1'b0);
    @(negedge clk);
    check("rst_mid_m0_ack_neg", ack_of(0), 1'b0);
    check("rst_mid_s_cyc_neg", wb_s_if.cyc, 1'b0);
    tick;
    rst_n = 1'b1;
    #1;
    check("rst_rel_grant", grant, 2'b00);
    tick;
    check("rst_rel_owner", grant, 2'b01);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;

    // randomized cyc traffic against a round-robin ownership model
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    own = -1;
    last = 1;
    cyc_m[0] = 1'b0;
    cyc_m[1] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      check("rnd_grant", grant, grant_for(own));
      if (own >= 0) begin
        check("rnd_s_cyc", wb_s_if.cyc, cyc_m[own]);
        check("rnd_nonowner_ack", ack_of(1 - own), 1'b0);
      end else begin
        check("rnd_idle_s_cyc", wb_s_if.cyc, 1'b0);
        check("rnd_idle_acks", ack_of(0) | ack_of(1), 1'b0);
      end
      @(posedge clk);
      if (!(own >= 0 && cyc_m[own])) begin
        if (own >= 0) last = own;
        pref = 1 - last;
        if (cyc_m[pref])          own = pref;
        else if (cyc_m[1 - pref]) own = 1 - pref;
        else                      own = -1;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(3) == 0) cyc_m[m] = !cyc_m[m];
        drive(m, cyc_m[m], 1'b0, {22'd0, 8'($urandom_range(255)), 2'b00}, 32'h0, CTI_CLASSIC);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    tick;

`ifdef WB_ARB_TIMEOUT_EN
    // stalled slave: 15 stall cycles, one err cycle, then hand over to pending m1
    stub_noack = 1'b1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    tick;
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, CTI_CLASSIC);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("to_stall_err", wb_m0_if.err, 1'b0);
      check("to_stall_grant", grant, 2'b01);
      @(posedge clk);
    end
    @(negedge clk);
    check("to_err", wb_m0_if.err, 1'b1);
    check("to_kill_s_cyc", wb_s_if.cyc, 1'b0);
    check("to_m1_err", wb_m1_if.err, 1'b0);
    tick;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    check("to_idle_grant", grant, 2'b00);
    check("to_err_one_cycle", wb_m0_if.err, 1'b0);
    tick;
    check("to_m1_granted", grant, 2'b10);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    stub_noack = 1'b0;
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
